// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory-access stage with fixed-latency word RAM and MEM/WB register
module mem_stage #(
    parameter int DEPTH_WORDS = 512,
    parameter int LAT         = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        RegWriteM,
    input  logic        MemtoRegM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  WriteRegM,
    output logic        StallM,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALUOutW,
    output logic [4:0]  WriteRegW
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LAT - 1);

    logic [31:0]   ram [DEPTH_WORDS];
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          reg_write_next;
    logic          mem_to_reg_next;
    logic [31:0]   read_data_next;
    logic [31:0]   alu_out_next;
    logic [4:0]    write_reg_next;
    logic [AW-1:0] idx;
    logic          memop;
    logic          done;

    // Word index drops the byte offset and anything above the RAM size, so addresses wrap.
    assign idx    = ALUOutM[AW+1:2];
    assign memop  = MemtoRegM | MemWriteM;
    assign done   = memop && (cnt == LAST);
    assign StallM = memop && (cnt != LAST);

    // Next-state: pass-through for ALU ops, bubble while waiting, full update on completion.
    always_comb begin
        cnt_next        = cnt;
        reg_write_next  = RegWriteW;
        mem_to_reg_next = MemtoRegW;
        read_data_next  = ReadDataW;
        alu_out_next    = ALUOutW;
        write_reg_next  = WriteRegW;
        if (!memop) begin
            cnt_next        = '0;
            reg_write_next  = RegWriteM;
            mem_to_reg_next = 1'b0;
            alu_out_next    = ALUOutM;
            write_reg_next  = WriteRegM;
        end else if (!done) begin
            cnt_next        = cnt + 1'b1;
            reg_write_next  = 1'b0;
            mem_to_reg_next = 1'b0;
            write_reg_next  = 5'd0;
        end else begin
            cnt_next        = '0;
            reg_write_next  = RegWriteM;
            mem_to_reg_next = MemtoRegM;
            alu_out_next    = ALUOutM;
            write_reg_next  = WriteRegM;
            if (MemtoRegM) begin
                read_data_next = ram[idx];
            end
        end
    end

    // Latency counter and MEM/WB register; reset aborts any access in flight.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt       <= '0;
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            ReadDataW <= 32'd0;
            ALUOutW   <= 32'd0;
            WriteRegW <= 5'd0;
        end else begin
            cnt       <= cnt_next;
            RegWriteW <= reg_write_next;
            MemtoRegW <= mem_to_reg_next;
            ReadDataW <= read_data_next;
            ALUOutW   <= alu_out_next;
            WriteRegW <= write_reg_next;
        end
    end

    // RAM write only on the completion edge; contents survive reset but a store under reset is dropped.
    always_ff @(posedge CLK) begin
        if (RESET && done && MemWriteM) begin
            ram[idx] <= WriteDataM;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized and directed checks of mem_stage at LAT 2, 1 and 4
module tb_mem_stage;
    logic        CLK = 1'b0;
    logic        RESET;
    logic        RegWriteM, MemtoRegM, MemWriteM;
    logic [31:0] ALUOutM, WriteDataM;
    logic [4:0]  WriteRegM;

    logic        stall_o [3];
    logic        rw_o    [3];
    logic        mtr_o   [3];
    logic [31:0] rd_o    [3];
    logic [31:0] alu_o   [3];
    logic [4:0]  wr_o    [3];

    int vectors     = 0;
    int miscompares = 0;
    int lat_of [3]  = '{2, 1, 4};

    logic [31:0] mram  [3][512];
    logic        m_rw  [3];
    logic        m_mtr [3];
    logic [31:0] m_rd  [3];
    logic [31:0] m_alu [3];
    logic [4:0]  m_wr  [3];

    always #5 CLK = ~CLK;

    mem_stage #(.DEPTH_WORDS(512), .LAT(2)) dut0 (
        .CLK(CLK), .RESET(RESET), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .MemWriteM(MemWriteM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
        .StallM(stall_o[0]), .RegWriteW(rw_o[0]), .MemtoRegW(mtr_o[0]), .ReadDataW(rd_o[0]),
        .ALUOutW(alu_o[0]), .WriteRegW(wr_o[0]));
    mem_stage #(.DEPTH_WORDS(512), .LAT(1)) dut1 (
        .CLK(CLK), .RESET(RESET), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .MemWriteM(MemWriteM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
        .StallM(stall_o[1]), .RegWriteW(rw_o[1]), .MemtoRegW(mtr_o[1]), .ReadDataW(rd_o[1]),
        .ALUOutW(alu_o[1]), .WriteRegW(wr_o[1]));
    mem_stage #(.DEPTH_WORDS(512), .LAT(4)) dut2 (
        .CLK(CLK), .RESET(RESET), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .MemWriteM(MemWriteM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
        .StallM(stall_o[2]), .RegWriteW(rw_o[2]), .MemtoRegW(mtr_o[2]), .ReadDataW(rd_o[2]),
        .ALUOutW(alu_o[2]), .WriteRegW(wr_o[2]));

    task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s dut%0d: observed %h expected %h", tag, k, obs, exp);
        end
    endtask

    task automatic check_w(input int k);
        check("RegWriteW", k, {31'd0, rw_o[k]},  {31'd0, m_rw[k]});
        check("MemtoRegW", k, {31'd0, mtr_o[k]}, {31'd0, m_mtr[k]});
        check("ReadDataW", k, rd_o[k],  m_rd[k]);
        check("ALUOutW",   k, alu_o[k], m_alu[k]);
        check("WriteRegW", k, {27'd0, wr_o[k]},  {27'd0, m_wr[k]});
    endtask

    task automatic zero_models();
        for (int k = 0; k < 3; k++) begin
            m_rw[k] = 1'b0; m_mtr[k] = 1'b0; m_rd[k] = 32'd0; m_alu[k] = 32'd0; m_wr[k] = 5'd0;
        end
    endtask

    task automatic set_in(input logic rw, input logic mtr, input logic mw,
                          input logic [31:0] a, input logic [31:0] d, input logic [4:0] r);
        RegWriteM = rw; MemtoRegM = mtr; MemWriteM = mw; ALUOutM = a; WriteDataM = d; WriteRegM = r;
    endtask

    // Holds one instruction on the inputs for as long as DUT k needs it and checks every cycle.
    task automatic run_op(input int k, input logic rw, input logic mtr, input logic mw,
                          input logic [31:0] a, input logic [31:0] d, input logic [4:0] r);
        logic        mem;
        int          n;
        int          w;
        logic [31:0] old;
        set_in(rw, mtr, mw, a, d, r);
        mem = mtr | mw;
        n   = mem ? lat_of[k] : 1;
        w   = int'((a / 4) % 512);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            check("StallM", k, {31'd0, stall_o[k]}, {31'd0, (mem && (i != n - 1))});
            @(posedge CLK);
            #1;
            if (i != n - 1) begin
                m_rw[k] = 1'b0; m_mtr[k] = 1'b0; m_wr[k] = 5'd0;
            end else begin
                m_rw[k] = rw; m_mtr[k] = mem ? mtr : 1'b0; m_alu[k] = a; m_wr[k] = r;
                if (mem) begin
                    old = mram[k][w];
                    if (mw)  mram[k][w] = d;
                    if (mtr) m_rd[k] = old;
                end
            end
            check_w(k);
        end
    endtask

    task automatic apply_reset();
        RESET = 1'b0;
        set_in(0, 0, 0, 32'd0, 32'd0, 5'd0);
        zero_models();
        #1;
        for (int k = 0; k < 3; k++) check_w(k);
        @(posedge CLK);
        #1;
        RESET = 1'b1;
    endtask

    task automatic prewrite(input int k);
        for (int i = 0; i <= 16; i++) run_op(k, 0, 0, 1, 32'(i * 4), 32'd0, 5'd0);
    endtask

    task automatic random_ops(input int k, input int count);
        int          kind;
        logic [31:0] a;
        for (int i = 0; i < count; i++) begin
            kind = int'($urandom_range(0, 3));
            a = ($urandom & 32'hFFFF_F800) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            case (kind)
                0:       run_op(k, 1'($urandom), 0, 0, $urandom, $urandom, 5'($urandom));
                1:       run_op(k, 1'($urandom), 1, 0, a, $urandom, 5'($urandom));
                2:       run_op(k, 1'($urandom), 0, 1, a, $urandom, 5'($urandom));
                default: run_op(k, 1'($urandom), 1, 1, a, $urandom, 5'($urandom));
            endcase
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 512; i++) mram[k][i] = 32'd0;
        apply_reset();

        // LAT=2: reset aborts an in-flight store.
        prewrite(0);
        set_in(0, 0, 1, 32'h10, 32'hDEADBEEF, 5'd0);
        @(negedge CLK);
        check("StallM_pre_abort", 0, {31'd0, stall_o[0]}, 32'd1);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        zero_models();
        #1;
        for (int k = 0; k < 3; k++) begin
            check_w(k);
            check("StallM_in_reset", k, {31'd0, stall_o[k]}, {31'd0, (lat_of[k] != 1)});
        end
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        run_op(0, 1, 1, 0, 32'h10, 32'd0, 5'd3);
        check("abort_read", 0, rd_o[0], 32'h0000_0000);

        // LAT=2: pass-through, store/load, address wrap.
        run_op(0, 1, 0, 0, 32'h1234, 32'd0, 5'd5);
        check("pass_alu", 0, alu_o[0], 32'h1234);
        run_op(0, 0, 0, 1, 32'h40, 32'hCAFEF00D, 5'd0);
        run_op(0, 1, 1, 0, 32'h40, 32'd0, 5'd7);
        check("load_cafe", 0, rd_o[0], 32'hCAFEF00D);
        run_op(0, 0, 0, 1, 32'h40, 32'h0, 5'd0);
        run_op(0, 0, 0, 1, 32'h803, 32'h11, 5'd0);
        run_op(0, 1, 1, 0, 32'h000, 32'd0, 5'd2);
        check("wrap_load", 0, rd_o[0], 32'h11);
        run_op(0, 0, 1, 1, 32'h000, 32'h22, 5'd4);
        check("both_old", 0, rd_o[0], 32'h11);
        random_ops(0, 40);

        // LAT=1: back-to-back stores and loads never stall.
        apply_reset();
        prewrite(1);
        for (int r = 0; r < 3; r++)
            for (int j = 0; j < 3; j++) begin
                run_op(1, 0, 0, 1, 32'(j * 4), $urandom, 5'd0);
                run_op(1, 1, 1, 0, 32'(j * 4), 32'd0, 5'(j + 1));
            end
        random_ops(1, 40);

        // LAT=4: three stall cycles and three bubbles per access.
        apply_reset();
        prewrite(2);
        run_op(2, 0, 0, 1, 32'h24, 32'h0BADC0DE, 5'd0);
        run_op(2, 1, 1, 0, 32'h24, 32'd0, 5'd9);
        check("lat4_load", 2, rd_o[2], 32'h0BADC0DE);
        random_ops(2, 40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage pipeline: consumes the EX/MEM pipeline register outputs, performs the data-memory load or store, and drives the MEM/WB register outputs toward write-back. Holds a word-addressed data RAM with a configurable access latency. Multi-cycle accesses raise `StallM` so the upstream stages, including the EX/MEM register, freeze until the access completes.

## Interface
- `DEPTH_WORDS`, 512: data RAM depth in 32-bit words; power of two; `AW = log2(DEPTH_WORDS)`.
- `LAT`, 2: cycles per load/store access; legal range 1..8.
- `CLK`  input  1  pipeline clock; all state updates on the rising edge.
- `RESET`  input  1  asynchronous, active-low reset.
- `RegWriteM`  input  1  register-file write enable from EX/MEM.
- `MemtoRegM`  input  1  load: write-back takes memory data.
- `MemWriteM`  input  1  store request.
- `ALUOutM`  input  32  byte address for load/store; ALU result otherwise.
- `WriteDataM`  input  32  store data.
- `WriteRegM`  input  5  destination register.
- `StallM`  output  1  combinational; high while a memory access is incomplete.
- `RegWriteW`  output  1  MEM/WB register-file write enable.
- `MemtoRegW`  output  1  MEM/WB write-back select.
- `ReadDataW`  output  32  loaded word.
- `ALUOutW`  output  32  ALU result passed through.
- `WriteRegW`  output  5  destination register.

## Operation
- A memory op is present when `MemtoRegM | MemWriteM`. `MemtoRegM & MemWriteM` together is illegal and treated as a store followed by a read of the same word in one completion edge. The read returns the old data.
- Word index = `ALUOutM[AW+1:2]`. Bits [1:0] are ignored. Higher bits are ignored, so addresses wrap modulo `DEPTH_WORDS*4`.
- Latency counter `cnt` runs 0..LAT-1, giving two states: IDLE (`cnt==0`) and WAIT (`cnt!=0`).
- `StallM = memop && (cnt != LAT-1)`.
- Non-memory op: `StallM=0`. At the edge, MEM/WB loads `RegWriteM`, `MemtoRegM=0`, `ALUOutM`, `WriteRegM`. `ReadDataW` holds. `cnt` stays 0.
- Memory op, `cnt < LAT-1`: at the edge `cnt <= cnt+1`. MEM/WB loads a bubble: `RegWriteW=0`, `MemtoRegW=0`, `WriteRegW=0`; `ReadDataW` and `ALUOutW` hold. No RAM write.
- Memory op, `cnt == LAT-1` (completion edge):
  - if `MemWriteM`, `RAM[idx] <= WriteDataM`;
  - if `MemtoRegM`, `ReadDataW <=` pre-edge `RAM[idx]`;
  - MEM/WB loads `RegWriteM`, `MemtoRegM`, `ALUOutM`, `WriteRegM`;
  - `cnt <= 0`.
- `LAT=1`: every op completes in one cycle and `StallM` is never high.
- Upstream holds all EX/MEM inputs stable while `StallM=1`. The block does not latch them; changed inputs mid-access are used as presented.
- Back-to-back store then load to the same word: the load completes after the store's completion edge, so it returns the stored data.
- RAM contents are zero-initialized at time 0 and not affected by `RESET`.

## Timing
- `RESET` low, at any time: `cnt=0`, `RegWriteW=0`, `MemtoRegW=0`, `ReadDataW=0`, `ALUOutW=0`, `WriteRegW=0`.
  - `StallM` follows its equation with `cnt=0`.
  - An in-flight access is aborted; its store is not performed.
- First edge after `RESET` rises behaves as IDLE.
- Non-memory op latency: 1 cycle (input to MEM/WB).
- Memory op latency: LAT cycles, with `StallM` high for LAT-1 of them.
- `RegWriteW` pulses for exactly one cycle per completed instruction. It is never high during bubbles.

## Test plan
- Reset: drive `RESET=0` mid-WAIT of a store of 0xDEADBEEF to address 0x10. Then read 0x10 → all W outputs 0 during reset, `cnt=0`, and the read returns 0x00000000 (store aborted).
- ALU pass-through with LAT=2: `RegWriteM=1`, `ALUOutM=0x1234`, `WriteRegM=5`, no memop → next cycle `RegWriteW=1`, `ALUOutW=0x1234`, `WriteRegW=5`, `StallM=0` throughout.
- Store then load with LAT=2:
  - store 0xCAFEF00D to 0x40 → `StallM` high 1 cycle, one bubble;
  - load 0x40 to r7 → `StallM` high 1 cycle, then `ReadDataW=0xCAFEF00D`, `MemtoRegW=1`, `WriteRegW=7`, `RegWriteW=1` for one cycle.
- Address wrap and low bits with DEPTH_WORDS=512: store 0x11 to 0x803 (index 0) → load 0x000 returns 0x11.
- LAT=1 regression: alternate stores and loads to 0x0, 0x4, 0x8 every cycle → `StallM` never high; each load returns the value stored to that address in an earlier cycle.
- LAT=4: a load holds `StallM` high for exactly 3 cycles and produces 3 bubbles with `RegWriteW=0`; data is valid on cycle 4.
